// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared constants and FSM state type for the interrupt host port
package int_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_RAW    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int HOLDOFF_DEF = 3;

    localparam logic [7:0] MASK_RST = 8'hFF;
    localparam logic [7:0] CTRL_RST = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ACK,
        ST_HOLD,
        ST_ACCESS
    } state_t;

endpackage

// File: rtl/int_host_if_if.sv
// rtl/int_host_if_if.sv - host bus and detector signals of the interrupt host port
interface int_host_if_if;
    logic [7:0] intreg_n;
    logic       oping;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       irq;

    modport slave (
        input  intreg_n, cs, rd, wr, addr, wdata,
        output oping, rdata, ack, irq
    );

    modport master (
        output intreg_n, cs, rd, wr, addr, wdata,
        input  oping, rdata, ack, irq
    );
endinterface

// File: rtl/int_host_if.sv
// rtl/int_host_if.sv - masked irq generation and CPU read/write handshake for the interrupt detector
module int_host_if
    import int_pkg::*;
#(
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic          clk,
    input  logic          rst,
    int_host_if_if.slave  bus
);

    localparam int CW = (HOLDOFF > 4) ? $clog2(HOLDOFF) : 2;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLDOFF - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    mask;
    logic [7:0]    ctrl;
    logic [7:0]    raw;
    logic [7:0]    pending;
    logic [7:0]    rmux;
    logic          req;

    assign raw     = ~bus.intreg_n;
    assign pending = raw & mask;
    assign req     = bus.cs & (bus.rd | bus.wr);

    always_comb begin
        rmux = ctrl;
        case (bus.addr)
            ADDR_STATUS: rmux = pending;
            ADDR_MASK:   rmux = mask;
            ADDR_RAW:    rmux = raw;
            default:     rmux = ctrl;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mask      <= MASK_RST;
            ctrl      <= CTRL_RST;
            bus.oping <= 1'b0;
            bus.ack   <= 1'b0;
            bus.rdata <= 8'h00;
            bus.irq   <= 1'b0;
        end else begin
            // The vector is untrusted while the detector clears and reloads.
            bus.irq <= ctrl[0] & (state != ST_HOLD) & (|pending);

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (bus.rd && bus.addr == ADDR_STATUS) begin
                            state     <= ST_LATCH;
                            bus.oping <= 1'b1;
                            bus.rdata <= pending;
                        end else begin
                            state <= ST_ACCESS;
                            if (bus.rd) begin
                                bus.rdata <= rmux;
                            end else if (bus.addr == ADDR_MASK) begin
                                mask <= bus.wdata;
                            end else if (bus.addr == ADDR_CTRL) begin
                                ctrl <= bus.wdata;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    state   <= ST_ACK;
                    bus.ack <= 1'b1;
                end
                ST_ACK: begin
                    if (!(bus.cs && bus.rd)) begin
                        state     <= ST_HOLD;
                        bus.ack   <= 1'b0;
                        bus.oping <= 1'b0;
                        cnt       <= CNT_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (!req) begin
                        state   <= ST_IDLE;
                        bus.ack <= 1'b0;
                    end else begin
                        bus.ack <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_host_if.sv
// tb/tb_int_host_if.sv - self-checking bench for int_host_if with a transaction-level reference model
module tb_int_host_if;
    import int_pkg::*;

    localparam int HOLDOFF = HOLDOFF_DEF;

    logic clk = 1'b0;
    logic rst;
    int_host_if_if bus();

    int_host_if #(.HOLDOFF(HOLDOFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_mask;
    logic [7:0] m_ctrl;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] a, input logic [7:0] v_n);
        case (a)
            2'd0:    return ~v_n & m_mask;
            2'd1:    return m_mask;
            2'd2:    return ~v_n;
            default: return m_ctrl;
        endcase
    endfunction

    function automatic logic model_irq(input logic [7:0] v_n);
        return m_ctrl[0] & (|(~v_n & m_mask));
    endfunction

    task automatic access(input logic [1:0] a, input logic do_rd, input logic do_wr,
                          input logic [7:0] d, output logic [7:0] q, output bit saw_oping);
        int n;
        saw_oping = 1'b0;
        bus.cs = 1'b1; bus.rd = do_rd; bus.wr = do_wr; bus.addr = a; bus.wdata = d;
        n = 0;
        do begin
            tick(); n++; saw_oping |= bus.oping;
        end while (!bus.ack && n < 20);
        expect_eq("ack_rise", bus.ack, 1'b1);
        q = bus.rdata;
        if (do_wr && !do_rd) begin
            if (a == ADDR_MASK) m_mask = d;
            if (a == ADDR_CTRL) m_ctrl = d;
        end
        bus_idle();
        n = 0;
        do begin
            tick(); n++; saw_oping |= bus.oping;
        end while (bus.ack && n < 20);
        expect_eq("ack_fall", bus.ack, 1'b0);
        repeat (HOLDOFF + 1) tick();
    endtask

    logic [7:0] q;
    bit         so;
    logic [7:0] v;
    logic [7:0] exp_q;
    int         n;
    int         rises;
    logic       prev_op;

    initial begin
        rst = 1'b1;
        bus_idle();
        bus.addr = 2'd0; bus.wdata = 8'h00; bus.intreg_n = 8'hFF;
        m_mask = MASK_RST; m_ctrl = CTRL_RST;
        tick(); tick();
        expect_eq("rst_oping", bus.oping, 1'b0);
        expect_eq("rst_ack",   bus.ack,   1'b0);
        expect_eq("rst_rdata", bus.rdata, 8'h00);
        expect_eq("rst_irq",   bus.irq,   1'b0);
        rst = 1'b0;
        tick();

        // Basic status read with exact hold-off timing
        bus.intreg_n = 8'hF6;
        tick();
        expect_eq("irq_lag", bus.irq, 1'b1);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = ADDR_STATUS;
        tick();
        expect_eq("st_oping_e0", bus.oping, 1'b1);
        expect_eq("st_rdata",    bus.rdata, 8'h09);
        expect_eq("st_ack_e0",   bus.ack,   1'b0);
        tick();
        expect_eq("st_ack_e1",   bus.ack,   1'b1);
        expect_eq("st_oping_e1", bus.oping, 1'b1);
        tick();
        expect_eq("st_oping_hold", bus.oping, 1'b1);
        bus_idle();
        tick();
        expect_eq("st_ack_k",   bus.ack,   1'b0);
        expect_eq("st_oping_k", bus.oping, 1'b0);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = ADDR_MASK;
        for (int i = 1; i <= HOLDOFF; i++) begin
            tick();
            expect_eq("hold_irq", bus.irq, 1'b0);
            expect_eq("hold_ack", bus.ack, 1'b0);
        end
        tick();
        expect_eq("post_hold_irq",   bus.irq,   1'b1);
        expect_eq("post_hold_ack",   bus.ack,   1'b0);
        expect_eq("post_hold_oping", bus.oping, 1'b0);
        tick();
        expect_eq("late_req_ack",   bus.ack,   1'b1);
        expect_eq("late_req_rdata", bus.rdata, 8'hFF);
        bus_idle();
        tick(); tick();

        // Masking
        access(ADDR_MASK, 1'b0, 1'b1, 8'h01, q, so);
        expect_eq("mask01_irq", bus.irq, 1'b1);
        access(ADDR_MASK, 1'b0, 1'b1, 8'h08, q, so);
        expect_eq("mask08_irq", bus.irq, 1'b1);
        access(ADDR_MASK, 1'b0, 1'b1, 8'h30, q, so);
        expect_eq("mask30_irq", bus.irq, 1'b0);
        access(ADDR_RAW, 1'b1, 1'b0, 8'h00, q, so);
        expect_eq("raw_rdata", q, 8'h09);
        expect_eq("raw_no_oping", so, 1'b0);

        // Enable
        access(ADDR_MASK, 1'b0, 1'b1, 8'hFF, q, so);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = ADDR_CTRL; bus.wdata = 8'h00;
        tick();
        tick();
        expect_eq("en_off_irq_next", bus.irq, 1'b0);
        m_ctrl = 8'h00;
        bus_idle();
        repeat (3) tick();
        access(ADDR_CTRL, 1'b1, 1'b0, 8'h00, q, so);
        expect_eq("ctrl_readback", q, 8'h00);
        access(ADDR_CTRL, 1'b0, 1'b1, 8'h01, q, so);
        expect_eq("en_on_irq", bus.irq, 1'b1);

        // Read wins over simultaneous write
        access(ADDR_MASK, 1'b1, 1'b1, 8'h55, q, so);
        expect_eq("rdwr_old_mask", q, 8'hFF);
        access(ADDR_MASK, 1'b1, 1'b0, 8'h00, q, so);
        expect_eq("rdwr_mask_kept", q, 8'hFF);

        // Reset in the middle of a status read
        access(ADDR_MASK, 1'b0, 1'b1, 8'h0F, q, so);
        access(ADDR_CTRL, 1'b0, 1'b1, 8'h81, q, so);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = ADDR_STATUS;
        tick(); tick();
        expect_eq("mid_ack",   bus.ack,   1'b1);
        expect_eq("mid_oping", bus.oping, 1'b1);
        expect_eq("mid_irq",   bus.irq,   1'b1);
        #2 rst = 1'b1;
        #1;
        expect_eq("async_oping", bus.oping, 1'b0);
        expect_eq("async_ack",   bus.ack,   1'b0);
        expect_eq("async_irq",   bus.irq,   1'b0);
        bus_idle();
        tick();
        rst = 1'b0;
        m_mask = MASK_RST; m_ctrl = CTRL_RST;
        tick();
        access(ADDR_MASK, 1'b1, 1'b0, 8'h00, q, so);
        expect_eq("rst_mask", q, 8'hFF);
        access(ADDR_CTRL, 1'b1, 1'b0, 8'h00, q, so);
        expect_eq("rst_ctrl", q, 8'h01);

        // Back-to-back status reads with a detector reload in between
        bus.intreg_n = 8'hF6;
        tick();
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = ADDR_STATUS;
        n = 0;
        do begin tick(); n++; end while (!bus.ack && n < 20);
        expect_eq("b2b_first_ack", bus.ack, 1'b1);
        expect_eq("b2b_first_rdata", bus.rdata, 8'h09);
        bus.rd = 1'b0;
        tick();
        expect_eq("b2b_oping_fall", bus.oping, 1'b0);
        bus.rd = 1'b1;
        bus.intreg_n = 8'hFF;
        n = 0; rises = 0; prev_op = 1'b0;
        do begin
            tick(); n++;
            if (bus.oping && !prev_op) rises++;
            prev_op = bus.oping;
            if (n == 2) bus.intreg_n = 8'h7E;
        end while (!bus.ack && n < 20);
        expect_eq("b2b_second_ack_edge", n, HOLDOFF + 2);
        expect_eq("b2b_one_pulse", rises, 1);
        expect_eq("b2b_second_rdata", bus.rdata, 8'h81);
        bus_idle();
        n = 0;
        do begin tick(); n++; end while (bus.ack && n < 20);
        expect_eq("b2b_ack_fall", bus.ack, 1'b0);
        repeat (HOLDOFF + 1) tick();

        // Randomized transactions against the register-level model
        for (int it = 0; it < 40; it++) begin
            int op;
            logic [1:0] a;
            logic [7:0] d;
            v = 8'($urandom);
            bus.intreg_n = v;
            tick(); tick();
            op = $urandom_range(0, 3);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            exp_q = model_read(a, v);
            if (op == 0) begin
                access(a, 1'b0, 1'b1, d, q, so);
                expect_eq("rnd_wr_no_oping", so, 1'b0);
            end else begin
                access(a, 1'b1, (op == 3), d, q, so);
                expect_eq("rnd_rdata", q, exp_q);
                expect_eq("rnd_oping", so, (a == ADDR_STATUS));
            end
            expect_eq("rnd_irq", bus.irq, model_irq(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
